// File: rtl/jtag_pkg.sv
// Shared definitions for the JTAG user-register chain: default parameters
// and frame field offsets. Frame layout, LSB first on the wire:
//   [0] write enable, [ADDR_W:1] address, [FRAME_W-1:ADDR_W+1] data.
package jtag_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_N_REGS = 4;

    function automatic int we_bit();
        return 0;
    endfunction

    function automatic int addr_lsb();
        return 1;
    endfunction

    function automatic int data_lsb(input int addr_w);
        return addr_w + 1;
    endfunction

    function automatic int frame_w(input int data_w, input int addr_w);
        return 1 + addr_w + data_w;
    endfunction

endpackage

// File: rtl/jtag_reg_chain.sv
// JTAG user data register chain: a TAP-driven shift frame that writes a
// small flop-based register file on Update-DR.
// Optional feature macro: JTAG_REG_READBACK_EN. When defined, Capture-DR
// loads the register addressed by the last update back into the frame.
// When undefined, capture loads zeros and the read pointer does not exist.
module jtag_reg_chain
    import jtag_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int N_REGS = DEF_N_REGS
) (
    input  logic                       JTCK,
    input  logic                       JRST,
    input  logic                       JTDI,
    input  logic                       JSHIFT,
    input  logic                       JUPDATE,
    input  logic                       JCE,
    output logic                       JTDO,
    output logic [N_REGS*DATA_W-1:0]   regs_flat,
    output logic                       upd_strobe,
    output logic [$clog2(N_REGS)-1:0]  upd_addr,
    output logic                       addr_err
);

    localparam int ADDR_W   = $clog2(N_REGS);
    localparam int WE_BIT   = we_bit();
    localparam int ADDR_LSB = addr_lsb();
    localparam int DATA_LSB = data_lsb(ADDR_W);
    localparam int FRAME_W  = frame_w(DATA_W, ADDR_W);

    logic [FRAME_W-1:0] sr_q, sr_d;
    logic               tdo_q, tdo_d;
    logic               armed_q, armed_d;
    logic               strobe_q, strobe_d;
    logic               err_q, err_d;
    logic [ADDR_W-1:0]  upd_addr_q, upd_addr_d;
    logic [DATA_W-1:0]  regs_q [N_REGS];
    logic [DATA_W-1:0]  regs_d [N_REGS];

    // Decoded fields of the frame as it stood before this cycle's shift.
    logic               fr_we;
    logic [ADDR_W-1:0]  fr_addr;
    logic [DATA_W-1:0]  fr_data;
    logic               fr_addr_ok;

    assign fr_we      = sr_q[WE_BIT];
    assign fr_addr    = sr_q[ADDR_LSB +: ADDR_W];
    assign fr_data    = sr_q[DATA_LSB +: DATA_W];
    assign fr_addr_ok = 32'(fr_addr) < N_REGS;

`ifdef JTAG_REG_READBACK_EN
    logic [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0]  rd_data;

    // A pointer left out of range by a read-only update reads back as zero.
    assign rd_data = (32'(rd_ptr_q) < N_REGS) ? regs_q[rd_ptr_q] : '0;
`endif

    // Next-state: capture or shift the frame, then apply a pending update.
    always_comb begin
        sr_d       = sr_q;
        tdo_d      = tdo_q;
        armed_d    = armed_q;
        strobe_d   = 1'b0;
        err_d      = err_q;
        upd_addr_d = upd_addr_q;
        regs_d     = regs_q;
`ifdef JTAG_REG_READBACK_EN
        rd_ptr_d   = rd_ptr_q;
`endif

        if (JCE) begin
            if (JSHIFT) begin
                tdo_d = sr_q[0];
                sr_d  = {JTDI, sr_q[FRAME_W-1:1]};
            end else begin
`ifdef JTAG_REG_READBACK_EN
                sr_d = {rd_data, rd_ptr_q, 1'b0};
`else
                sr_d = '0;
`endif
            end
        end

        // Only a frame that was actually shifted in may be committed.
        if (JUPDATE && armed_q) begin
            armed_d = 1'b0;
            if (fr_we && !fr_addr_ok) begin
                err_d = 1'b1;
            end else begin
`ifdef JTAG_REG_READBACK_EN
                rd_ptr_d = fr_addr;
`endif
                if (fr_we) begin
                    regs_d[fr_addr] = fr_data;
                    upd_addr_d      = fr_addr;
                    strobe_d        = 1'b1;
                end
            end
        end

        // A shift in the same cycle as an update re-arms for the new frame.
        if (JCE && JSHIFT) begin
            armed_d = 1'b1;
        end
    end

    // State registers with synchronous reset overriding every other input.
    always_ff @(posedge JTCK) begin
        if (JRST) begin
            sr_q       <= '0;
            tdo_q      <= 1'b0;
            armed_q    <= 1'b0;
            strobe_q   <= 1'b0;
            err_q      <= 1'b0;
            upd_addr_q <= '0;
            for (int k = 0; k < N_REGS; k++) begin
                regs_q[k] <= '0;
            end
`ifdef JTAG_REG_READBACK_EN
            rd_ptr_q   <= '0;
`endif
        end else begin
            sr_q       <= sr_d;
            tdo_q      <= tdo_d;
            armed_q    <= armed_d;
            strobe_q   <= strobe_d;
            err_q      <= err_d;
            upd_addr_q <= upd_addr_d;
            for (int k = 0; k < N_REGS; k++) begin
                regs_q[k] <= regs_d[k];
            end
`ifdef JTAG_REG_READBACK_EN
            rd_ptr_q   <= rd_ptr_d;
`endif
        end
    end

    assign JTDO       = tdo_q;
    assign upd_strobe = strobe_q;
    assign upd_addr   = upd_addr_q;
    assign addr_err   = err_q;

    for (genvar k = 0; k < N_REGS; k++) begin : g_flat
        assign regs_flat[k*DATA_W +: DATA_W] = regs_q[k];
    end

endmodule

// File: tb/tb_jtag_reg_chain.sv
// Bench for jtag_reg_chain: a 4-register instance for the main checks and a
// 3-register instance for out-of-range addressing. Expected writes go into a
// queue as frames are shifted and are popped when upd_strobe appears.
module tb_jtag_reg_chain;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst = 1'b1, a_tdi = 1'b0, a_sh = 1'b0, a_up = 1'b0, a_ce = 1'b0;
    logic        a_tdo, a_stb, a_err;
    logic [31:0] a_regs;
    logic [1:0]  a_uaddr;

    logic        b_rst = 1'b1, b_tdi = 1'b0, b_sh = 1'b0, b_up = 1'b0, b_ce = 1'b0;
    logic        b_tdo, b_stb, b_err;
    logic [23:0] b_regs;
    logic [1:0]  b_uaddr;

    jtag_reg_chain #(.DATA_W(8), .N_REGS(4)) dut_a (
        .JTCK(clk), .JRST(a_rst), .JTDI(a_tdi), .JSHIFT(a_sh), .JUPDATE(a_up),
        .JCE(a_ce), .JTDO(a_tdo), .regs_flat(a_regs), .upd_strobe(a_stb),
        .upd_addr(a_uaddr), .addr_err(a_err)
    );

    jtag_reg_chain #(.DATA_W(8), .N_REGS(3)) dut_b (
        .JTCK(clk), .JRST(b_rst), .JTDI(b_tdi), .JSHIFT(b_sh), .JUPDATE(b_up),
        .JCE(b_ce), .JTDO(b_tdo), .regs_flat(b_regs), .upd_strobe(b_stb),
        .upd_addr(b_uaddr), .addr_err(b_err)
    );

    int total = 0;
    int bad = 0;
    int a_scnt = 0;
    int b_scnt = 0;
    logic [9:0] wq [$];
    logic [7:0] exp_regs [4] = '{default: 8'h00};

    function automatic logic [31:0] exp_flat();
        return {exp_regs[3], exp_regs[2], exp_regs[1], exp_regs[0]};
    endfunction

    task automatic push_write(input logic [1:0] addr, input logic [7:0] data);
        wq.push_back({addr, data});
        exp_regs[addr] = data;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input bit onb, input logic ce, input logic sh,
                       input logic di, input logic up);
        if (onb) begin
            b_ce = ce; b_sh = sh; b_tdi = di; b_up = up;
        end else begin
            a_ce = ce; a_sh = sh; a_tdi = di; a_up = up;
        end
    endtask

    task automatic shift_frame(input logic [10:0] f, input int n, input bit onb);
        for (int i = 0; i < n; i++) begin
            drv(onb, 1'b1, 1'b1, f[i], 1'b0);
            tick();
        end
        drv(onb, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic update(input bit onb);
        drv(onb, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        drv(onb, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Scoreboard side: every strobe on the 4-register instance must match
    // the oldest outstanding expected write.
    always @(negedge clk) begin
        if (a_stb === 1'b1) begin
            logic [9:0] e;
            int ea;
            a_scnt++;
            total++;
            if (wq.size() == 0) begin
                bad++;
                $display("FAIL strobe_unexpected got addr=%0d regs=%h want no strobe", a_uaddr, a_regs);
            end else begin
                e  = wq.pop_front();
                ea = int'(e[9:8]);
                if (a_uaddr !== e[9:8] || a_regs[ea*8 +: 8] !== e[7:0]) begin
                    bad++;
                    $display("FAIL strobe_write got addr=%0d data=%h want addr=%0d data=%h",
                             a_uaddr, a_regs[ea*8 +: 8], e[9:8], e[7:0]);
                end
            end
        end
        if (b_stb === 1'b1) b_scnt++;
    end

    task automatic test_reset();
        a_rst = 1'b1; b_rst = 1'b1;
        tick(); tick();
        total++;
        if ({a_tdo, a_regs, a_stb, a_uaddr, a_err} !== '0) begin
            bad++;
            $display("FAIL reset_a got tdo=%b regs=%h stb=%b uaddr=%0d err=%b want all 0",
                     a_tdo, a_regs, a_stb, a_uaddr, a_err);
        end
        total++;
        if ({b_tdo, b_regs, b_stb, b_uaddr, b_err} !== '0) begin
            bad++;
            $display("FAIL reset_b got tdo=%b regs=%h stb=%b uaddr=%0d err=%b want all 0",
                     b_tdo, b_regs, b_stb, b_uaddr, b_err);
        end
        a_rst = 1'b0; b_rst = 1'b0;
        tick();
    endtask

    task automatic test_write();
        int s0;
        push_write(2'd2, 8'hA5);
        shift_frame(11'h52D, 11, 1'b0);
        s0 = a_scnt;
        update(1'b0);
        total++;
        if (a_regs !== 32'h00A5_0000) begin
            bad++;
            $display("FAIL write_regs got %h want %h", a_regs, 32'h00A5_0000);
        end
        total++;
        if (a_stb !== 1'b1 || a_uaddr !== 2'd2) begin
            bad++;
            $display("FAIL write_strobe got stb=%b uaddr=%0d want stb=1 uaddr=2", a_stb, a_uaddr);
        end
        tick();
        total++;
        if (a_stb !== 1'b0 || a_uaddr !== 2'd2 || a_scnt - s0 !== 1) begin
            bad++;
            $display("FAIL write_pulse got stb=%b uaddr=%0d pulses=%0d want stb=0 uaddr=2 pulses=1",
                     a_stb, a_uaddr, a_scnt - s0);
        end
    endtask

    task automatic test_readback();
        logic [10:0] exp;
        push_write(2'd1, 8'h5A);
        shift_frame(11'h2D3, 11, 1'b0);
        update(1'b0);
`ifdef JTAG_REG_READBACK_EN
        shift_frame(11'h004, 11, 1'b0);
        update(1'b0);
        exp = 11'h52C;
`else
        exp = 11'h000;
`endif
        drv(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 11; i++) begin
            drv(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
            tick();
            total++;
            if (a_tdo !== exp[i]) begin
                bad++;
                $display("FAIL readback_bit%0d got %b want %b", i, a_tdo, exp[i]);
            end
        end
        drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        total++;
        if (a_regs !== exp_flat()) begin
            bad++;
            $display("FAIL readback_regs got %h want %h", a_regs, exp_flat());
        end
    endtask

    task automatic test_stray();
        int s0;
        push_write(2'd3, 8'h3C);
        shift_frame(11'h1E7, 11, 1'b0);
        s0 = a_scnt;
        update(1'b0);
        tick();
        update(1'b0);
        tick(); tick();
        total++;
        if (a_scnt - s0 !== 1 || a_regs !== exp_flat()) begin
            bad++;
            $display("FAIL stray_update got pulses=%0d regs=%h want pulses=1 regs=%h",
                     a_scnt - s0, a_regs, exp_flat());
        end
    endtask

    task automatic test_back_to_back();
        int s0;
        logic [10:0] fb;
        fb = 11'h61D;
        push_write(2'd0, 8'h11);
        push_write(2'd2, 8'hC3);
        s0 = a_scnt;
        shift_frame(11'h089, 11, 1'b0);
        // first bit of the next frame shifts in on the same edge as the update
        for (int i = 0; i < 11; i++) begin
            drv(1'b0, 1'b1, 1'b1, fb[i], (i == 0) ? 1'b1 : 1'b0);
            tick();
        end
        drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        update(1'b0);
        tick();
        total++;
        if (a_scnt - s0 !== 2 || a_regs !== 32'h3CC3_5A11 || a_uaddr !== 2'd2) begin
            bad++;
            $display("FAIL back_to_back got pulses=%0d regs=%h uaddr=%0d want pulses=2 regs=3cc35a11 uaddr=2",
                     a_scnt - s0, a_regs, a_uaddr);
        end
    endtask

    task automatic test_bad_addr();
        int sb;
        sb = b_scnt;
        shift_frame(11'h3BB, 11, 1'b1);
        update(1'b1);
        tick();
        total++;
        if (b_regs !== 24'h00_7700 || b_scnt - sb !== 1 || b_err !== 1'b0) begin
            bad++;
            $display("FAIL bad_addr_pre got regs=%h pulses=%0d err=%b want regs=007700 pulses=1 err=0",
                     b_regs, b_scnt - sb, b_err);
        end
        sb = b_scnt;
        shift_frame(11'h7FF, 11, 1'b1);
        update(1'b1);
        tick();
        total++;
        if (b_regs !== 24'h00_7700 || b_err !== 1'b1 || b_uaddr !== 2'd1 || b_scnt - sb !== 0) begin
            bad++;
            $display("FAIL bad_addr got regs=%h err=%b uaddr=%0d pulses=%0d want regs=007700 err=1 uaddr=1 pulses=0",
                     b_regs, b_err, b_uaddr, b_scnt - sb);
        end
        repeat (5) tick();
        shift_frame(11'h211, 11, 1'b1);
        update(1'b1);
        tick();
        total++;
        if (b_err !== 1'b1 || b_regs !== 24'h00_7742) begin
            bad++;
            $display("FAIL bad_addr_sticky got err=%b regs=%h want err=1 regs=007742", b_err, b_regs);
        end
        b_rst = 1'b1;
        tick();
        b_rst = 1'b0;
        total++;
        if (b_err !== 1'b0 || b_regs !== 24'h0) begin
            bad++;
            $display("FAIL bad_addr_clear got err=%b regs=%h want err=0 regs=000000", b_err, b_regs);
        end
    endtask

    task automatic test_reset_midshift();
        int s0;
        logic [10:0] f;
        f = 11'h52D;
        s0 = a_scnt;
        for (int i = 0; i < 5; i++) begin
            drv(1'b0, 1'b1, 1'b1, f[i], 1'b0);
            tick();
        end
        a_rst = 1'b1;
        tick();
        a_rst = 1'b0;
        drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) exp_regs[k] = 8'h00;
        update(1'b0);
        total++;
        if ({a_tdo, a_regs, a_stb, a_uaddr, a_err} !== '0) begin
            bad++;
            $display("FAIL reset_midshift got tdo=%b regs=%h stb=%b uaddr=%0d err=%b want all 0",
                     a_tdo, a_regs, a_stb, a_uaddr, a_err);
        end
        tick(); tick();
        total++;
        if (a_scnt - s0 !== 0 || a_regs !== exp_flat()) begin
            bad++;
            $display("FAIL reset_midshift_nowrite got pulses=%0d regs=%h want pulses=0 regs=%h",
                     a_scnt - s0, a_regs, exp_flat());
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_readback();
        test_stray();
        test_back_to_back();
        test_bad_addr();
        test_reset_midshift();
        total++;
        if (wq.size() != 0) begin
            bad++;
            $display("FAIL missing_strobes got %0d outstanding want 0", wq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/jtag_reg_chain.md
JTAG_REG_CHAIN -- requirements
Module: jtag_reg_chain

Interface
REQ-001 SHALL declare parameter DATA_W, default 8, width of each user register.
REQ-002 SHALL declare parameter N_REGS, default 4, number of user registers (2..256); ADDR_W = clog2(N_REGS) is derived, not overridable.
REQ-003 SHALL declare port JTCK, input, 1, the only clock; all logic on rising edge.
REQ-004 SHALL declare port JRST, input, 1, reset: synchronous, active-high.
REQ-005 SHALL declare port JTDI, input, 1, serial data from the TAP.
REQ-006 SHALL declare port JSHIFT, input, 1, TAP in Shift-DR.
REQ-007 SHALL declare port JUPDATE, input, 1, TAP in Update-DR.
REQ-008 SHALL declare port JCE, input, 1, this chain selected (capture/shift enable).
REQ-009 SHALL declare port JTDO, output, 1, registered serial data to the TAP.
REQ-010 SHALL declare port regs_flat, output, N_REGS*DATA_W, all registers; reg k at [k*DATA_W +: DATA_W].
REQ-011 SHALL declare port upd_strobe, output, 1, one-cycle pulse on a successful write.
REQ-012 SHALL declare port upd_addr, output, ADDR_W, address of the last write; held between writes.
REQ-013 SHALL declare port addr_err, output, 1, sticky flag: an out-of-range write was attempted.

Function
REQ-014 SHALL use a shift register of FRAME_W = 1+ADDR_W+DATA_W bits: [0]=WE, [ADDR_W:1]=ADDR, [FRAME_W-1:ADDR_W+1]=DATA.
REQ-015 When JCE=1 and JSHIFT=1, SHALL load JTDO <= sr[0] and sr <= {JTDI, sr[FRAME_W-1:1]} (LSB first), and SHALL set armed=1.
REQ-016 When JCE=1 and JSHIFT=0, SHALL capture: sr <= {regs[rd_ptr], rd_ptr, 1'b0}.
REQ-017 When JUPDATE=1 and armed=1, SHALL clear armed, set rd_ptr <= ADDR, and, if WE=1 and ADDR<N_REGS, write regs[ADDR] <= DATA, upd_addr <= ADDR, and assert upd_strobe for exactly the next cycle.
REQ-018 When WE=1 and ADDR>=N_REGS at update, SHALL leave regs, upd_addr and rd_ptr unchanged, set addr_err=1, and issue no strobe.
REQ-019 When JUPDATE=1 and armed=0, SHALL have no effect; a stray update without a preceding shift never writes.
REQ-020 When JUPDATE and a shift coincide, update SHALL use sr contents before that cycle's shift, and armed SHALL end at 1.
REQ-021 SHALL clear addr_err only on reset.
REQ-022 SHALL deassert upd_strobe on every cycle that is not the one immediately following a valid write; back-to-back writes give separate pulses.

Reset
REQ-023 On JRST=1 at a clock edge, SHALL clear regs, sr, rd_ptr, upd_addr, armed, JTDO, upd_strobe and addr_err to 0; reset overrides all other inputs.
REQ-024 Reset asserted mid-shift SHALL discard the partial frame; a following JUPDATE without new shifting SHALL not write.

Configuration
REQ-025 SHALL honour macro JTAG_REG_READBACK_EN. When defined, capture SHALL follow REQ-016. When undefined, capture SHALL load sr <= 0, rd_ptr SHALL be omitted, and the read-only path logic SHALL not be synthesised.

Structure
REQ-026 SHALL place the frame field offsets (WE_BIT, ADDR_LSB, DATA_LSB) as functions of DATA_W/ADDR_W, and the default parameter values, in shared package jtag_pkg.
REQ-027 SHALL be a single module with no sub-modules; the register file is an array of flops, not inferred RAM.

Verification
REQ-028 Write: DATA_W=8, N_REGS=4, FRAME_W=11; shift 0x52D LSB-first, then JUPDATE -> regs[2]=0xA5, upd_strobe high 1 cycle, upd_addr=2.
REQ-029 Readback (macro defined): after REQ-028, shift 0x004, update, then capture -> sr=0x52C; next 11 shifts give JTDO=0,0,1,1,0,1,0,0,1,0,1.
REQ-030 Bad address: with N_REGS=3, shift 0x7FF and update -> regs unchanged, addr_err=1, no strobe; addr_err stays 1 until JRST.
REQ-031 Stray update: pulse JUPDATE twice after one write -> only one strobe, regs unchanged by the second pulse.
REQ-032 Reset mid-shift: shift 5 bits, assert JRST 1 cycle, then JUPDATE -> all outputs 0, no write.
REQ-033 Macro undefined: write 0x5A to reg 1, then capture -> sr=0; JTDO shifts out eleven 0s.
